vram_write_scheduler: RTL and testbench

VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

---
 rtl/vram_write_scheduler_pkg.sv | 13 +
 rtl/vram_rr_arbiter2.sv | 29 ++
 rtl/vram_write_scheduler.sv | 124 ++++++++++++
 tb/tb_vram_write_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_write_scheduler_pkg.sv
// Shared defaults and fill-engine state encoding for the VRAM write scheduler.
package vram_write_scheduler_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_FINISH = 2'd2
    } fill_state_t;

endpackage

// File: rtl/vram_rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered priority pointer.
module vram_rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req_cpu,
    input  logic req_fill,
    output logic grant_cpu,
    output logic grant_fill
);

    logic favour_fill;

    always_comb begin
        grant_cpu  = req_cpu && (!req_fill || !favour_fill);
        grant_fill = req_fill && !grant_cpu;
    end

    // After any grant the other requester gets priority on the next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            favour_fill <= 1'b0;
        end else if (grant_cpu) begin
            favour_fill <= 1'b1;
        end else if (grant_fill) begin
            favour_fill <= 1'b0;
        end
    end

endmodule

// File: rtl/vram_write_scheduler.sv
// Merges CPU writes and a block-fill engine onto one registered VRAM write port.
module vram_write_scheduler
    import vram_write_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_ack,
    input  logic                  fill_start,
    input  logic                  fill_abort,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH-1:0] fill_count,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_data,
    output logic                  vram_we
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    fill_state_t           state;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [ADDR_WIDTH-1:0] fill_left;
    logic [DATA_WIDTH-1:0] fill_value_q;
    logic                  cpu_pending;
    logic                  fill_pending;
    logic                  grant_cpu;
    logic                  grant_fill;

    // A CPU request is ignored while its ack is out, so it is never written twice.
    assign cpu_pending  = cpu_req && !cpu_ack;
    assign fill_pending = (state == ST_FILL) && !fill_abort;

    vram_rr_arbiter2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_cpu    (cpu_pending),
        .req_fill   (fill_pending),
        .grant_cpu  (grant_cpu),
        .grant_fill (grant_fill)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            fill_addr    <= '0;
            fill_left    <= '0;
            fill_value_q <= '0;
            fill_busy    <= 1'b0;
            fill_done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fill_start && !fill_abort) begin
                        fill_addr    <= fill_base;
                        fill_left    <= fill_count;
                        fill_value_q <= fill_value;
                        if (fill_count == '0) begin
                            state     <= ST_FINISH;
                            fill_done <= 1'b1;
                        end else begin
                            state     <= ST_FILL;
                            fill_busy <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (fill_abort) begin
                        state     <= ST_IDLE;
                        fill_busy <= 1'b0;
                    end else if (grant_fill) begin
                        fill_addr <= fill_addr + ONE;
                        fill_left <= fill_left - ONE;
                        if (fill_left == ONE) begin
                            state     <= ST_FINISH;
                            fill_busy <= 1'b0;
                            fill_done <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    state     <= ST_IDLE;
                    fill_done <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    fill_busy <= 1'b0;
                    fill_done <= 1'b0;
                end
            endcase
        end
    end

    // Address and data hold their last value when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
            cpu_ack   <= 1'b0;
        end else if (grant_cpu) begin
            vram_we   <= 1'b1;
            vram_addr <= cpu_addr;
            vram_data <= cpu_data;
            cpu_ack   <= 1'b1;
        end else if (grant_fill) begin
            vram_we   <= 1'b1;
            vram_addr <= fill_addr;
            vram_data <= fill_value_q;
            cpu_ack   <= 1'b0;
        end else begin
            vram_we   <= 1'b0;
            cpu_ack   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Self-checking bench: per-cycle comparison against a job-level model plus directed scenarios.
module tb_vram_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [15:0] cpu_data = '0;
    logic        cpu_ack;
    logic        fill_start = 1'b0;
    logic        fill_abort = 1'b0;
    logic [11:0] fill_base = '0;
    logic [11:0] fill_count = '0;
    logic [15:0] fill_value = '0;
    logic        fill_busy;
    logic        fill_done;
    logic [11:0] vram_addr;
    logic [15:0] vram_data;
    logic        vram_we;

    int checks = 0;
    int errors = 0;

    // Model state: a fill job is described by base, total and how many words went out.
    bit          m_active, m_last_cpu;
    int          m_issued, m_total, m_base;
    logic [15:0] m_value;
    logic        e_we, e_ack, e_busy, e_done;
    logic [11:0] e_addr;
    logic [15:0] e_data;

    logic [11:0] log_addr[$];
    logic [15:0] log_data[$];
    int          busy_cycles, done_cycles, ack_cycles;

    vram_write_scheduler #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .fill_start(fill_start), .fill_abort(fill_abort), .fill_base(fill_base),
        .fill_count(fill_count), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_last_cpu = 0; m_issued = 0; m_total = 0; m_base = 0; m_value = '0;
        e_we = 0; e_ack = 0; e_busy = 0; e_done = 0; e_addr = '0; e_data = '0;
    endtask

    task automatic model_step();
        bit cpu_pend, fill_pend, gc, gf, done_next;
        cpu_pend = cpu_req && !e_ack;
        fill_pend = m_active && !fill_abort;
        gc = cpu_pend && (!fill_pend || !m_last_cpu);
        gf = fill_pend && !gc;
        if (gc) begin
            e_we = 1; e_ack = 1; e_addr = cpu_addr; e_data = cpu_data; m_last_cpu = 1;
        end else if (gf) begin
            e_we = 1; e_ack = 0; e_addr = 12'((m_base + m_issued) % 4096); e_data = m_value;
            m_last_cpu = 0;
        end else begin
            e_we = 0; e_ack = 0;
        end
        done_next = 0;
        if (m_active) begin
            if (fill_abort) m_active = 0;
            else if (gf) begin
                m_issued++;
                if (m_issued == m_total) begin
                    m_active = 0;
                    done_next = 1;
                end
            end
        end else if (!e_done && fill_start && !fill_abort) begin
            m_base = int'(fill_base); m_value = fill_value; m_total = int'(fill_count); m_issued = 0;
            if (fill_count == 0) done_next = 1;
            else m_active = 1;
        end
        e_done = done_next;
        e_busy = m_active;
    endtask

    initial model_reset();

    // Advance the model on each edge, then compare DUT outputs shortly after.
    always @(posedge clk) begin
        if (!rst) model_reset();
        else model_step();
        #1;
        check_output("vram_we", 32'(vram_we), 32'(e_we));
        check_output("cpu_ack", 32'(cpu_ack), 32'(e_ack));
        check_output("fill_busy", 32'(fill_busy), 32'(e_busy));
        check_output("fill_done", 32'(fill_done), 32'(e_done));
        check_output("vram_addr", 32'(vram_addr), 32'(e_addr));
        check_output("vram_data", 32'(vram_data), 32'(e_data));
        if (vram_we) begin
            log_addr.push_back(vram_addr);
            log_data.push_back(vram_data);
        end
        if (fill_busy) busy_cycles++;
        if (fill_done) done_cycles++;
        if (cpu_ack) ack_cycles++;
    end

    task automatic clear_log();
        log_addr.delete(); log_data.delete();
        busy_cycles = 0; done_cycles = 0; ack_cycles = 0;
    endtask

    task automatic apply_stimulus(input logic [11:0] base, input logic [11:0] count, input logic [15:0] value);
        @(negedge clk);
        fill_start = 1; fill_base = base; fill_count = count; fill_value = value;
        @(negedge clk);
        fill_start = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (cpu_req && cpu_ack) cpu_req = 0;
        end
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (log_addr.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (log_addr.size() < n) check_output("wait_writes_timeout", 32'(log_addr.size()), 32'(n));
    endtask

    initial begin
        // Reset state held for a few cycles.
        repeat (3) @(negedge clk);
        check_output("reset_we", 32'(vram_we), 32'd0);
        check_output("reset_addr", 32'(vram_addr), 32'd0);
        check_output("reset_busy", 32'(fill_busy), 32'd0);
        rst = 1;
        idle_cycles(2);

        // Single CPU write.
        clear_log();
        cpu_req = 1; cpu_addr = 12'h123; cpu_data = 16'hBEEF;
        @(negedge clk);
        check_output("cpu_we", 32'(vram_we), 32'd1);
        check_output("cpu_addr", 32'(vram_addr), 32'h123);
        check_output("cpu_data", 32'(vram_data), 32'hBEEF);
        check_output("cpu_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 0;
        idle_cycles(4);
        check_output("cpu_write_count", 32'(log_addr.size()), 32'd1);

        // Plain fill of three words.
        clear_log();
        apply_stimulus(12'h010, 12'd3, 16'h00FF);
        idle_cycles(8);
        check_output("fill3_count", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            check_output("fill3_a0", 32'(log_addr[0]), 32'h010);
            check_output("fill3_a1", 32'(log_addr[1]), 32'h011);
            check_output("fill3_a2", 32'(log_addr[2]), 32'h012);
            check_output("fill3_d2", 32'(log_data[2]), 32'h00FF);
        end
        check_output("fill3_busy_cycles", 32'(busy_cycles), 32'd3);
        check_output("fill3_done_cycles", 32'(done_cycles), 32'd1);

        // Address wrap at the top of memory.
        clear_log();
        apply_stimulus(12'hFFE, 12'd4, 16'h1234);
        idle_cycles(8);
        check_output("wrap_count", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            check_output("wrap_a1", 32'(log_addr[1]), 32'hFFF);
            check_output("wrap_a2", 32'(log_addr[2]), 32'h000);
            check_output("wrap_a3", 32'(log_addr[3]), 32'h001);
        end

        // CPU and fill contend from the same cycle.
        clear_log();
        @(negedge clk);
        cpu_req = 1; cpu_addr = 12'h0AA; cpu_data = 16'h5555;
        fill_start = 1; fill_base = 12'h200; fill_count = 12'd4; fill_value = 16'hA5A5;
        @(negedge clk);
        fill_start = 0;
        if (cpu_ack) cpu_req = 0;
        idle_cycles(10);
        check_output("contend_writes", 32'(log_addr.size()), 32'd5);
        check_output("contend_cpu_writes", 32'(ack_cycles), 32'd1);

        // Zero-length fill.
        clear_log();
        apply_stimulus(12'h300, 12'd0, 16'h7777);
        check_output("zero_done", 32'(fill_done), 32'd1);
        idle_cycles(4);
        check_output("zero_writes", 32'(log_addr.size()), 32'd0);

        // Abort after two of ten writes.
        clear_log();
        apply_stimulus(12'h400, 12'd10, 16'h0F0F);
        wait_writes(2, 20);
        fill_abort = 1;
        @(negedge clk);
        fill_abort = 0;
        idle_cycles(12);
        check_output("abort_writes_le3", 32'(log_addr.size() <= 3), 32'd1);
        check_output("abort_no_done", 32'(done_cycles), 32'd0);
        check_output("abort_idle", 32'(fill_busy), 32'd0);

        // Asynchronous reset in the middle of an eight-word fill.
        clear_log();
        apply_stimulus(12'h500, 12'd8, 16'hCAFE);
        wait_writes(5, 20);
        #2 rst = 0;
        #1;
        check_output("rst_we", 32'(vram_we), 32'd0);
        check_output("rst_addr", 32'(vram_addr), 32'd0);
        check_output("rst_data", 32'(vram_data), 32'd0);
        check_output("rst_busy", 32'(fill_busy), 32'd0);
        check_output("rst_done", 32'(fill_done), 32'd0);
        @(negedge clk);
        rst = 1;
        clear_log();
        idle_cycles(12);
        check_output("rst_after_writes", 32'(log_addr.size()), 32'd0);
        check_output("rst_after_done", 32'(done_cycles), 32'd0);

        // Randomized traffic checked cycle by cycle against the model.
        repeat (3000) begin
            @(negedge clk);
            fill_start = 0; fill_abort = 0;
            if (cpu_req && cpu_ack) begin
                if ($urandom_range(0, 1) == 0) cpu_req = 0;
                else begin
                    cpu_addr = 12'($urandom_range(0, 4095));
                    cpu_data = 16'($urandom);
                end
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1;
                cpu_addr = 12'($urandom_range(0, 4095));
                cpu_data = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                fill_start = 1;
                fill_base = 12'($urandom_range(0, 4095));
                fill_count = 12'($urandom_range(0, 12));
                fill_value = 16'($urandom);
            end
            if ($urandom_range(0, 39) == 0) fill_abort = 1;
        end
        @(negedge clk);
        fill_start = 0; fill_abort = 0; cpu_req = 0;
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
